sample_pacer: RTL
=================

# sample_pacer

- Upstream feeder for the signal-delay stage: accepts audio samples over a valid/ready handshake and optionally averages them in groups (decimation).
- Buffers results in a 2-entry holding queue and releases them at a programmable sample rate.
- On each sample tick drives the delay line's `din`, `wr_en`, `rd_en` and address-advance `en` with one-cycle strobes, so the counter/RAM pair advances exactly once per sample.

## Interface
- `D_WIDTH`, 8: sample width (matches the delay line data width).
- `DIV_WIDTH`, 16: width of the sample-period divider.
- `DEC_LOG2`, 2: log2 of the decimation factor N (N = 4 by default).

- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-low (`rst`=0 resets on the next edge).
- `in_valid` in 1: source sample valid.
- `in_data` in D_WIDTH: source sample, unsigned.
- `in_ready` out 1: block can accept a sample this cycle.
- `div` in DIV_WIDTH: tick period is `div`+1 cycles.
- `dec_en` in 1: 1 = average N samples per output; 0 = pass-through.
- `out_data` out D_WIDTH: sample to the delay line `din`.
- `wr_en` out 1: one-cycle write strobe.
- `rd_en` out 1: one-cycle read strobe.
- `en` out 1: one-cycle address-advance strobe.
- `underrun` out 1: sticky, a tick found the queue empty.

## Operation
- **Accept:** a sample is accepted when `in_valid & in_ready`.
- **Ready:** `in_ready = rst & (qcount < 2)`.
- **Pass-through** (`dec_en`=0): each accepted sample is pushed into the queue.
- **Decimation** (`dec_en`=1):
  - Accumulator is D_WIDTH+DEC_LOG2 bits; phase counter runs 0..N-1.
  - Phases 0..N-2 add `in_data` into the accumulator.
  - Phase N-1 pushes `(acc + in_data) >> DEC_LOG2` (truncating) into the queue, then clears the accumulator and phase.
- **`dec_en` change:** sampled per accepted sample. A change mid-group discards the partial accumulator and resets phase to 0.
- **Queue:** 2-entry FIFO with `qcount` 0..2. Push and pop in the same cycle are both performed and leave `qcount` unchanged. Push is only possible when `qcount` < 2, so overflow cannot occur.
- **Tick counter:**
  - `tcnt` loads `div` at reset.
  - Each cycle: if `tcnt`==0, assert tick and reload `div`; otherwise decrement.
  - `div`=0 gives a tick every cycle.
  - A new `div` value takes effect at the next reload.
- **On tick, queue non-empty:** pop the head into `out_data`.
- **On tick, queue empty:** hold `out_data` at its previous value and set `underrun`. Strobes still pulse so the delay line keeps advancing.
- **Strobes:** `wr_en`, `rd_en` and `en` are identical, registered, high for exactly one cycle per tick.
- **`underrun`:** cleared only by reset.

## Timing
- **Reset values:** `out_data`=0, `wr_en`=`rd_en`=`en`=0, `underrun`=0, `in_ready`=0 while `rst`=0. Queue, accumulator and phase are cleared; `tcnt`=`div`.
- **After reset release:** `in_ready` is 1 in the first cycle with `rst`=1. The first tick occurs in cycle `div`+1 after release (cycle 1 = first cycle with `rst`=1).
- **Push latency:** an accepted pass-through sample is in the queue at the next edge. It is eligible for a tick in the following cycle or later.
- **Tick to output:** a tick in cycle T makes `out_data` and the three strobes valid in cycle T+1. The strobes drop in T+2 unless another tick occurred in T+1.
- **Full queue:** a pop in cycle T raises `in_ready` in T+1.
- **Reset mid-operation:** takes effect at the next edge. All in-flight data (partial accumulator, queued samples) is discarded. No strobe is issued in the cycle after reset.

## Configuration
- **`SAMPLE_PACER_DECIMATE_EN` defined:** accumulator, phase counter and averaging path are present, and behaviour follows `dec_en`.
- **`SAMPLE_PACER_DECIMATE_EN` undefined:** no accumulator or phase logic. `dec_en` is ignored and every accepted sample is pushed directly, as with `dec_en`=0.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with `div`=3. Expect all outputs 0 and `in_ready`=0. Release; expect `in_ready`=1 immediately and the first strobe in cycle 5 after release, with `out_data` still 0 and `underrun`=1 (queue empty).
- **Pass-through:** `dec_en`=0, `div`=3. Push 0x10, 0x20, 0x30 back-to-back. Expect `in_ready`=0 after two accepts; 0x30 accepted only after the first pop. Expect `out_data` 0x10, 0x20, 0x30 on strobes 4 cycles apart, each strobe 1 cycle wide.
- **Decimation:** `dec_en`=1, DEC_LOG2=2. Push 10, 20, 30, 41. Expect exactly one output of 25 (101>>2). Pushing 255 ×4 gives 255, with no overflow.
- **Underrun hold:** after one output of 0x55, supply no input for 3 ticks. Expect `out_data` to stay 0x55, three strobe pulses, and `underrun`=1 remaining set.
- **Tick every cycle:** `div`=0 with `in_valid` held at 1 and `dec_en`=0. Expect a strobe every cycle and a continuous data stream with no drops or duplicates once the queue is primed.
- **Reset mid-group:** `dec_en`=1. Accept 2 samples of 0xFF, pulse `rst`=0 for 1 cycle, then accept 4 samples of 0x40. Expect exactly one output of 0x40.

Source files
------------

// File: rtl/sample_pacer.sv
// Sample pacer: handshake intake, optional N-sample averaging, 2-entry queue, and
// per-tick strobes for the delay line. Averaging is built only with SAMPLE_PACER_DECIMATE_EN.
module sample_pacer #(
  parameter int D_WIDTH   = 8,
  parameter int DIV_WIDTH = 16,
  parameter int DEC_LOG2  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [D_WIDTH-1:0]   in_data,
  output logic                 in_ready,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 dec_en,
  output logic [D_WIDTH-1:0]   out_data,
  output logic                 wr_en,
  output logic                 rd_en,
  output logic                 en,
  output logic                 underrun
);

  logic [1:0]           qcount;
  logic [D_WIDTH-1:0]   q0, q1;
  logic [DIV_WIDTH-1:0] tcnt;
  logic                 tick_p0, accept, push, pop, stb_p1;
  logic [D_WIDTH-1:0]   push_data;

  assign in_ready = rst & (qcount < 2'd2);
  assign accept   = in_valid & in_ready;
  assign tick_p0  = (tcnt == '0);
  assign pop      = tick_p0 & (qcount != 2'd0);

`ifdef SAMPLE_PACER_DECIMATE_EN
  localparam int A_W  = D_WIDTH + DEC_LOG2;
  localparam int PH_W = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
  localparam int N    = 1 << DEC_LOG2;

  logic [A_W-1:0]  acc, acc_eff, sum;
  logic [PH_W-1:0] phase, ph_eff;
  logic            dec_prev, restart, grp_done;

  function automatic logic [D_WIDTH-1:0] avg_trunc(input logic [A_W-1:0] s);
    avg_trunc = D_WIDTH'(s >> DEC_LOG2);
  endfunction

  // A mode change on an accepted sample drops the partial group before this sample counts
  always_comb begin
    restart   = (dec_en != dec_prev);
    ph_eff    = restart ? '0 : phase;
    acc_eff   = restart ? '0 : acc;
    sum       = acc_eff + A_W'(in_data);
    grp_done  = (ph_eff == PH_W'(N - 1));
    push      = accept & (~dec_en | grp_done);
    push_data = dec_en ? avg_trunc(sum) : in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc      <= '0;
      phase    <= '0;
      dec_prev <= 1'b0;
    end else if (accept) begin
      dec_prev <= dec_en;
      if (!dec_en || grp_done) begin
        acc   <= '0;
        phase <= '0;
      end else begin
        acc   <= sum;
        phase <= ph_eff + PH_W'(1);
      end
    end
  end
`else
  logic unused_dec_en;
  assign unused_dec_en = dec_en;
  assign push          = accept;
  assign push_data     = in_data;
`endif

  // Stage p0 -> p1: tick decision registered into the strobes and output sample
  always_ff @(posedge clk) begin
    if (!rst) begin
      qcount   <= 2'd0;
      tcnt     <= div;
      out_data <= '0;
      stb_p1   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      tcnt   <= tick_p0 ? div : tcnt - DIV_WIDTH'(1);
      stb_p1 <= tick_p0;
      if (pop)
        out_data <= q0;
      else if (tick_p0)
        underrun <= 1'b1;
      case ({push, pop})
        2'b10:   qcount <= qcount + 2'd1;
        2'b01:   qcount <= qcount - 2'd1;
        default: qcount <= qcount;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && (pop || qcount == 2'd0))
      q0 <= push_data;
    else if (pop)
      q0 <= q1;
    if (push && !pop && qcount == 2'd1)
      q1 <= push_data;
  end

  assign wr_en = stb_p1;
  assign rd_en = stb_p1;
  assign en    = stb_p1;

endmodule
